// File: rtl/regfl_wr_arb_if.sv
// Bundle between the write-port arbiter and the rest of the system: the
// client-side write requests and the register-file write port it drives.
//
// Handshake: a client raises reqN with addrN/dataN and keeps all three
// stable until it sees gntN high. gntN is a one-cycle pulse, issued on the
// same edge that puts the write on wr_e/wr_addr/wr_data. If reqN is still
// high at an edge where gntN is already high, that is a fresh request.
// The register file captures wr_addr/wr_data on the edge after wr_e rises.
interface regfl_wr_arb_if #(
    parameter int W = 8,
    parameter int A = 2
);
    logic         init;
    logic         req0;
    logic [A-1:0] addr0;
    logic [W-1:0] data0;
    logic         req1;
    logic [A-1:0] addr1;
    logic [W-1:0] data1;
    logic         gnt0;
    logic         gnt1;
    logic         busy;
    logic         wr_e;
    logic [A-1:0] wr_addr;
    logic [W-1:0] wr_data;
    // Debug view of the controller: 1 while arbitrating, 0 while clearing.
    logic         dbg_arb;

    modport master (
        output init, req0, addr0, data0, req1, addr1, data1,
        input  gnt0, gnt1, busy, wr_e, wr_addr, wr_data, dbg_arb
    );

    modport slave (
        input  init, req0, addr0, data0, req1, addr1, data1,
        output gnt0, gnt1, busy, wr_e, wr_addr, wr_data, dbg_arb
    );
endinterface

// File: rtl/regfl_wr_arb.sv
// Write-port controller for a small register file. After reset or an init
// pulse it sweeps zero into every address, then shares the single write
// port between two clients with round-robin arbitration. Every output is a
// flop; grants and the write they launch appear on the same edge.
module regfl_wr_arb #(
    parameter int W = 8,
    parameter int A = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    regfl_wr_arb_if.slave        bus
);
    localparam int           DEPTH = 2 ** A;
    localparam logic [A-1:0] LAST  = A'(DEPTH - 1);

    typedef enum logic {
        S_CLR = 1'b0,
        S_ARB = 1'b1
    } state_t;

    state_t       state;
    logic [A-1:0] cnt;
    logic         ptr;      // client favoured when both request
    logic         gnt0_q;
    logic         gnt1_q;
    logic         busy_q;
    logic         wr_e_q;
    logic [A-1:0] wr_addr_q;
    logic [W-1:0] wr_data_q;
    logic         pick1;    // arbitration winner is client 1

    // Round-robin choice: a lone requester wins, a tie goes to ptr.
    always_comb begin
        pick1 = 1'b0;
        if (bus.req0 && bus.req1) begin
            pick1 = ptr;
        end else if (bus.req1) begin
            pick1 = 1'b1;
        end
    end

    // Controller: clear sweep, then arbitration; init restarts the sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_CLR;
            cnt       <= '0;
            ptr       <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b1;
            wr_e_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (bus.init) begin
            // init beats any request on the same edge; ptr is kept so the
            // fairness history survives a re-clear.
            state     <= S_CLR;
            cnt       <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b1;
            wr_e_q    <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            case (state)
                S_CLR: begin
                    gnt0_q    <= 1'b0;
                    gnt1_q    <= 1'b0;
                    busy_q    <= 1'b1;
                    wr_e_q    <= 1'b1;
                    wr_addr_q <= cnt;
                    wr_data_q <= '0;
                    cnt       <= cnt + A'(1);
                    // busy stays up through the last clear write and drops
                    // on the first arbitration edge.
                    if (cnt == LAST) begin
                        state <= S_ARB;
                    end
                end
                S_ARB: begin
                    busy_q <= 1'b0;
                    if (bus.req0 || bus.req1) begin
                        wr_e_q <= 1'b1;
                        ptr    <= ~pick1;
                        if (pick1) begin
                            gnt0_q    <= 1'b0;
                            gnt1_q    <= 1'b1;
                            wr_addr_q <= bus.addr1;
                            wr_data_q <= bus.data1;
                        end else begin
                            gnt0_q    <= 1'b1;
                            gnt1_q    <= 1'b0;
                            wr_addr_q <= bus.addr0;
                            wr_data_q <= bus.data0;
                        end
                    end else begin
                        // Idle: address and data hold their last value.
                        wr_e_q <= 1'b0;
                        gnt0_q <= 1'b0;
                        gnt1_q <= 1'b0;
                    end
                end
                default: begin
                    state <= S_CLR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.busy    = busy_q;
    assign bus.wr_e    = wr_e_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.dbg_arb = (state == S_ARB);
endmodule

// File: tb/tb_regfl_wr_arb.sv
// Bench for regfl_wr_arb: directed scenarios followed by randomized client
// traffic, compared each cycle against a rule-level reference model, with
// per-client ordered scoreboards and a shadow register file.
module tb_regfl_wr_arb;
    localparam int W     = 8;
    localparam int A     = 2;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    regfl_wr_arb_if #(.W(W), .A(A)) bus ();

    regfl_wr_arb #(.W(W), .A(A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Rule-level view: "clearing" with the next address to clear, or
    // "arbitrating" with a favoured client; outputs follow the rules.
    int m_clr, m_next, m_ptr;
    int m_gnt0, m_gnt1, m_busy, m_wr_e, m_addr, m_data;
    logic [W-1:0] exp_mem [DEPTH];
    logic [W-1:0] dut_mem [DEPTH];

    task automatic model_reset();
        m_clr = 1; m_next = 0; m_ptr = 0;
        m_gnt0 = 0; m_gnt1 = 0; m_busy = 1; m_wr_e = 0; m_addr = 0; m_data = 0;
    endtask

    task automatic model_step();
        int winner;
        m_gnt0 = 0;
        m_gnt1 = 0;
        if (bus.init) begin
            m_clr = 1; m_next = 0;
            m_busy = 1; m_wr_e = 1; m_addr = 0; m_data = 0;
        end else if (m_clr != 0) begin
            m_busy = 1; m_wr_e = 1; m_addr = m_next; m_data = 0;
            if (m_next == DEPTH - 1) m_clr = 0;
            else m_next = m_next + 1;
        end else begin
            m_busy = 0;
            winner = -1;
            if (bus.req0 && bus.req1) winner = m_ptr;
            else if (bus.req0) winner = 0;
            else if (bus.req1) winner = 1;
            if (winner == 0) begin
                m_gnt0 = 1; m_wr_e = 1; m_addr = int'(bus.addr0); m_data = int'(bus.data0);
                m_ptr = 1;
            end else if (winner == 1) begin
                m_gnt1 = 1; m_wr_e = 1; m_addr = int'(bus.addr1); m_data = int'(bus.data1);
                m_ptr = 0;
            end else begin
                m_wr_e = 0;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [A+W-1:0] exp_q0[$];
    logic [A+W-1:0] exp_q1[$];
    bit sb_on = 0;

    task automatic sb_check(input int c);
        logic [A+W-1:0] e;
        if (c == 0 && bus.gnt0 === 1'b1) begin
            if (exp_q0.size() == 0) chk("sb0_unexpected_gnt", 1, 0);
            else begin
                e = exp_q0.pop_front();
                chk("sb0_addr", 32'(bus.wr_addr), 32'(e[A+W-1:W]));
                chk("sb0_data", 32'(bus.wr_data), 32'(e[W-1:0]));
            end
        end
        if (c == 1 && bus.gnt1 === 1'b1) begin
            if (exp_q1.size() == 0) chk("sb1_unexpected_gnt", 1, 0);
            else begin
                e = exp_q1.pop_front();
                chk("sb1_addr", 32'(bus.wr_addr), 32'(e[A+W-1:W]));
                chk("sb1_data", 32'(bus.wr_data), 32'(e[W-1:0]));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input int c, input logic [A-1:0] a, input logic [W-1:0] d);
        if (c == 0) begin
            bus.req0 = 1'b1; bus.addr0 = a; bus.data0 = d;
            if (sb_on) exp_q0.push_back({a, d});
        end else begin
            bus.req1 = 1'b1; bus.addr1 = a; bus.data1 = d;
            if (sb_on) exp_q1.push_back({a, d});
        end
    endtask

    // One clock: the shadow register file captures what is presented before
    // the edge, then outputs are sampled 1 time unit after it.
    task automatic cycle();
        if (bus.wr_e === 1'b1) dut_mem[bus.wr_addr] = bus.wr_data;
        if (m_wr_e != 0) exp_mem[m_addr] = m_data[W-1:0];
        @(posedge clk);
        #1;
        model_step();
        chk("gnt0", 32'(bus.gnt0), 32'(m_gnt0));
        chk("gnt1", 32'(bus.gnt1), 32'(m_gnt1));
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("wr_e", 32'(bus.wr_e), 32'(m_wr_e));
        chk("wr_addr", 32'(bus.wr_addr), 32'(m_addr));
        chk("wr_data", 32'(bus.wr_data), 32'(m_data));
        chk("dbg_arb", 32'(bus.dbg_arb), 32'(m_clr == 0));
        chk("gnt_excl", 32'(bus.gnt0 & bus.gnt1), 0);
        if (sb_on) begin
            sb_check(0);
            sb_check(1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt0"}, 32'(bus.gnt0), 0);
        chk({tag, "_gnt1"}, 32'(bus.gnt1), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 1);
        chk({tag, "_wr_e"}, 32'(bus.wr_e), 0);
        chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
        chk({tag, "_wr_data"}, 32'(bus.wr_data), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        bus.init = 1'b0;
        bus.req0 = 1'b0; bus.addr0 = '0; bus.data0 = '0;
        bus.req1 = 1'b0; bus.addr1 = '0; bus.data1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            dut_mem[i] = 8'h5a;
            exp_mem[i] = 8'h5a;
        end
        model_reset();

        // 1: reset values, then the clear sweep
        #1 rst = 1'b1;
        #2 check_reset_outputs("rst");
        #5 rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cycle();
            chk("t1_clr_wr_e", 32'(bus.wr_e), 1);
            chk("t1_clr_addr", 32'(bus.wr_addr), i);
            chk("t1_clr_busy", 32'(bus.busy), 1);
        end
        cycle();
        chk("t1_busy_low", 32'(bus.busy), 0);
        chk("t1_wr_e_low", 32'(bus.wr_e), 0);
        for (int i = 0; i < DEPTH; i++) chk("t1_mem_zero", 32'(dut_mem[i]), 0);

        // 2: single client-0 write
        issue(0, 2'd2, 8'h2e);
        cycle();
        chk("t2_gnt0", 32'(bus.gnt0), 1);
        chk("t2_addr", 32'(bus.wr_addr), 2);
        chk("t2_data", 32'(bus.wr_data), 32'h2e);
        bus.req0 = 1'b0;
        cycle();
        chk("t2_one_cycle", 32'(bus.wr_e), 0);
        chk("t2_hold_addr", 32'(bus.wr_addr), 2);
        cycle();
        chk("t2_mem2", 32'(dut_mem[2]), 32'h2e);

        // single client-1 write returns the favour to client 0
        issue(1, 2'd3, 8'h11);
        cycle();
        chk("t2b_gnt1", 32'(bus.gnt1), 1);
        bus.req1 = 1'b0;
        cycle();

        // 3: both clients request continuously; grants alternate from 0
        issue(0, 2'd0, 8'ha2);
        issue(1, 2'd3, 8'h55);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("t3_gnt0", 32'(bus.gnt0), 32'(i % 2 == 0));
            chk("t3_gnt1", 32'(bus.gnt1), 32'(i % 2 == 1));
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        cycle();
        cycle();
        chk("t3_mem0", 32'(dut_mem[0]), 32'ha2);
        chk("t3_mem3", 32'(dut_mem[3]), 32'h55);

        // 4: both target address 1 at once; last granted wins
        issue(0, 2'd1, 8'h98);
        issue(1, 2'd1, 8'hff);
        cycle();
        chk("t4_first_gnt0", 32'(bus.gnt0), 1);
        bus.req0 = 1'b0;
        cycle();
        chk("t4_second_gnt1", 32'(bus.gnt1), 1);
        bus.req1 = 1'b0;
        cycle();
        cycle();
        chk("t4_mem1", 32'(dut_mem[1]), 32'hff);

        // 5: init while client 1 is pending; its write lands after the clear
        issue(1, 2'd2, 8'hc3);
        bus.init = 1'b1;
        cycle();
        bus.init = 1'b0;
        chk("t5_init_busy", 32'(bus.busy), 1);
        chk("t5_init_wr", 32'(bus.wr_e), 1);
        for (int k = 0; k < 12 && bus.busy === 1'b1; k++) begin
            chk("t5_no_gnt1", 32'(bus.gnt1), 0);
            cycle();
        end
        chk("t5_sweep_end", 32'(bus.busy), 0);
        chk("t5_gnt1", 32'(bus.gnt1), 1);
        chk("t5_data", 32'(bus.wr_data), 32'hc3);
        bus.req1 = 1'b0;
        cycle();
        cycle();
        chk("t5_mem2", 32'(dut_mem[2]), 32'hc3);
        chk("t5_mem0", 32'(dut_mem[0]), 0);

        // 6: reset mid-sweep with cnt=2
        bus.init = 1'b1;
        cycle();
        bus.init = 1'b0;
        cycle();
        cycle();
        chk("t6_pre_addr", 32'(bus.wr_addr), 1);
        #1 rst = 1'b1;
        #1 check_reset_outputs("t6_rst");
        model_reset();
        #4 rst = 1'b0;
        cycle();
        chk("t6_restart_addr", 32'(bus.wr_addr), 0);
        chk("t6_restart_wr_e", 32'(bus.wr_e), 1);
        for (int i = 0; i < DEPTH; i++) cycle();

        // 7: randomized traffic with occasional init pulses
        sb_on = 1;
        for (int n = 0; n < 400; n++) begin
            bus.init = ($urandom_range(0, 49) == 0);
            cycle();
            if (bus.gnt0 === 1'b1) bus.req0 = 1'b0;
            if (bus.gnt1 === 1'b1) bus.req1 = 1'b0;
            if (!bus.req0 && $urandom_range(0, 2) != 0)
                issue(0, A'($urandom_range(0, DEPTH - 1)), W'($urandom_range(0, 255)));
            if (!bus.req1 && $urandom_range(0, 2) != 0)
                issue(1, A'($urandom_range(0, DEPTH - 1)), W'($urandom_range(0, 255)));
        end
        bus.init = 1'b0;
        for (int k = 0; k < 40 && (bus.req0 || bus.req1); k++) begin
            cycle();
            if (bus.gnt0 === 1'b1) bus.req0 = 1'b0;
            if (bus.gnt1 === 1'b1) bus.req1 = 1'b0;
        end
        chk("drain_done", 32'(bus.req0 | bus.req1), 0);
        cycle();
        cycle();
        chk("sb0_left", exp_q0.size(), 0);
        chk("sb1_left", exp_q1.size(), 0);
        for (int i = 0; i < DEPTH; i++) chk("final_mem", 32'(dut_mem[i]), 32'(exp_mem[i]));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
